// File: rtl/nos_dac_receiver_if.sv
// Stream-side bundle for nos_dac_receiver: serial NOS lines in, stereo word out.
// NOS_RX_STAT_EN adds the err_cnt status output.
interface nos_dac_receiver_if #(
  parameter int I2S_BITS = 32
);
  logic                    bck;
  logic                    data_l;
  logic                    data_r;
  logic                    le;
  logic [5:0]              data_bits;
  logic [2*I2S_BITS-1:0]   data;
  logic                    valid;
  logic [6:0]              frame_bcks;
  logic                    short_frame;
`ifdef NOS_RX_STAT_EN
  logic [15:0]             err_cnt;

  modport master (output bck, data_l, data_r, le, data_bits,
                  input  data, valid, frame_bcks, short_frame, err_cnt);
  modport slave  (input  bck, data_l, data_r, le, data_bits,
                  output data, valid, frame_bcks, short_frame, err_cnt);
`else
  modport master (output bck, data_l, data_r, le, data_bits,
                  input  data, valid, frame_bcks, short_frame);
  modport slave  (input  bck, data_l, data_r, le, data_bits,
                  output data, valid, frame_bcks, short_frame);
`endif
endinterface

// File: rtl/nos_dac_receiver.sv
// Oversampling NOS serial receiver: deserializes L/R per le rise into a sign-extended stereo word.
// Optional NOS_RX_STAT_EN adds a saturating short-frame error counter (err_cnt).
module nos_dac_receiver #(
  parameter int I2S_BITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  nos_dac_receiver_if.slave  bus
);
  localparam int W  = I2S_BITS;
  localparam int IW = $clog2(W);

  typedef enum logic {SYNC, RUN} state_t;

  state_t           r_state;
  logic [2:0]       r_bck_s, r_le_s;
  logic [1:0]       r_dl_s, r_dr_s;
  logic             r_dl, r_dr;
  logic             r_bck_rise, r_le_rise;
  logic [W-1:0]     r_sl, r_sr;
  logic [6:0]       r_cnt;
  logic [2*W-1:0]   r_data;
  logic             r_valid;
  logic [6:0]       r_frame_bcks;
  logic             r_short;

  logic [W-1:0]     w_sl_nxt, w_sr_nxt, w_ext_l, w_ext_r;
  logic [6:0]       w_cnt_nxt;
  logic [5:0]       w_nbits;
  logic [IW-1:0]    w_msb;
  logic             w_short;

  // Data lines take the same two-stage path as bck so they line up with the registered rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bck_s    <= '0;
      r_le_s     <= '0;
      r_dl_s     <= '0;
      r_dr_s     <= '0;
      r_dl       <= 1'b0;
      r_dr       <= 1'b0;
      r_bck_rise <= 1'b0;
      r_le_rise  <= 1'b0;
    end else begin
      r_bck_s    <= {r_bck_s[1:0], bus.bck};
      r_le_s     <= {r_le_s[1:0], bus.le};
      r_dl_s     <= {r_dl_s[0], bus.data_l};
      r_dr_s     <= {r_dr_s[0], bus.data_r};
      r_dl       <= r_dl_s[1];
      r_dr       <= r_dr_s[1];
      r_bck_rise <= r_bck_s[1] & ~r_bck_s[2];
      r_le_rise  <= r_le_s[1] & ~r_le_s[2];
    end
  end

  always_comb begin
    w_sl_nxt  = r_bck_rise ? {r_sl[W-2:0], r_dl} : r_sl;
    w_sr_nxt  = r_bck_rise ? {r_sr[W-2:0], r_dr} : r_sr;
    w_cnt_nxt = (r_bck_rise && r_cnt != 7'd127) ? r_cnt + 7'd1 : r_cnt;
    if (bus.data_bits < 6'd16)
      w_nbits = 6'd16;
    else if (bus.data_bits > 6'(W))
      w_nbits = 6'(W);
    else
      w_nbits = bus.data_bits;
    w_msb   = IW'(w_nbits - 6'd1);
    w_short = w_cnt_nxt < {1'b0, w_nbits};
    w_ext_l = '0;
    w_ext_r = '0;
    for (int i = 0; i < W; i++) begin
      w_ext_l[i] = (i < int'(w_nbits)) ? w_sl_nxt[i] : w_sl_nxt[w_msb];
      w_ext_r[i] = (i < int'(w_nbits)) ? w_sr_nxt[i] : w_sr_nxt[w_msb];
    end
  end

`ifdef NOS_RX_STAT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (reset)
      r_err_cnt <= '0;
    else if (r_le_rise && r_state == RUN && w_short && r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign bus.err_cnt = r_err_cnt;
`endif

  // A bck rise coincident with le is shifted and counted before the frame closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SYNC;
      r_sl         <= '0;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_bcks <= '0;
      r_short      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_bck_rise) begin
        r_sl  <= w_sl_nxt;
        r_sr  <= w_sr_nxt;
        r_cnt <= w_cnt_nxt;
      end
      if (r_le_rise) begin
        r_cnt <= '0;
        case (r_state)
          SYNC: begin
            r_sl    <= '0;
            r_sr    <= '0;
            r_state <= RUN;
          end
          RUN: begin
            r_data       <= {w_ext_l, w_ext_r};
            r_frame_bcks <= w_cnt_nxt;
            r_short      <= w_short;
            r_valid      <= 1'b1;
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

  assign bus.data        = r_data;
  assign bus.valid       = r_valid;
  assign bus.frame_bcks  = r_frame_bcks;
  assign bus.short_frame = r_short;
endmodule

// File: tb/tb_nos_dac_receiver.sv
// Scoreboard bench for nos_dac_receiver: a bit-level model predicts each frame at le time,
// and a monitor pops and compares whenever valid strobes.
module tb_nos_dac_receiver;
  localparam int W = 32;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  fb;
    logic        sf;
    logic [15:0] err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nos_dac_receiver_if #(.I2S_BITS(W)) bus ();
  nos_dac_receiver #(.I2S_BITS(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_sl, m_sr;
  int          m_cnt;
  bit          m_run;
  logic [15:0] m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] m;
    m = 32'hFFFF_FFFF >> (32 - n);
    return v[n-1] ? (v | ~m) : (v & m);
  endfunction

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data", bus.data, e.data);
        check("frame_bcks", 64'(bus.frame_bcks), 64'(e.fb));
        check("short_frame", 64'(bus.short_frame), 64'(e.sf));
`ifdef NOS_RX_STAT_EN
        check("err_cnt", 64'(bus.err_cnt), 64'(e.err));
`endif
      end
    end
  end

  task automatic model_shift(input logic l, input logic r);
    m_sl = {m_sl[30:0], l};
    m_sr = {m_sr[30:0], r};
    if (m_cnt < 127) m_cnt++;
  endtask

  task automatic send_bit(input logic l, input logic r);
    bus.data_l = l;
    bus.data_r = r;
    repeat (3) @(negedge clk);
    bus.bck = 1'b1;
    model_shift(l, r);
    repeat (3) @(negedge clk);
    bus.bck = 1'b0;
  endtask

  // Closes a frame; with_bit puts one more bck rise on the same clk edge as le.
  task automatic latch(input logic [5:0] dbits, input bit with_bit, input logic l, input logic r);
    int   n;
    exp_t e;
    bus.data_bits = dbits;
    if (with_bit) begin
      bus.data_l = l;
      bus.data_r = r;
      repeat (3) @(negedge clk);
      bus.bck = 1'b1;
      model_shift(l, r);
    end
    bus.le = 1'b1;
    n = (dbits < 16) ? 16 : (dbits > W) ? W : int'(dbits);
    if (m_run) begin
      e.data = {sext(m_sl, n), sext(m_sr, n)};
      e.fb   = 7'(m_cnt);
      e.sf   = (m_cnt < n);
      if (e.sf && m_err != 16'hFFFF) m_err++;
      e.err  = m_err;
      q.push_back(e);
    end else begin
      m_sl  = '0;
      m_sr  = '0;
      m_run = 1'b1;
    end
    m_cnt = 0;
    repeat (3) @(negedge clk);
    bus.le  = 1'b0;
    bus.bck = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame(input int nb, input logic [63:0] lw, input logic [63:0] rw,
                       input logic [5:0] dbits, input bit coincident);
    int last;
    last = coincident ? 1 : 0;
    for (int i = nb - 1; i >= last; i--) send_bit(lw[i], rw[i]);
    latch(dbits, coincident, lw[0], rw[0]);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_data"}, bus.data, 64'd0);
    check({tag, "_valid"}, 64'(bus.valid), 64'd0);
    check({tag, "_fb"}, 64'(bus.frame_bcks), 64'd0);
    check({tag, "_sf"}, 64'(bus.short_frame), 64'd0);
    reset = 1'b0;
    m_sl  = '0;
    m_sr  = '0;
    m_cnt = 0;
    m_run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] dlist [4];
    dlist = '{6'd8, 6'd16, 6'd20, 6'd40};
    reset = 1'b1;
    bus.bck = 1'b0; bus.data_l = 1'b0; bus.data_r = 1'b0; bus.le = 1'b0;
    bus.data_bits = 6'd32;
    m_err = '0;
    repeat (3) @(negedge clk);
    do_reset("reset");
`ifdef NOS_RX_STAT_EN
    check("reset_err_cnt", 64'(bus.err_cnt), 64'd0);
`endif

    // First le after reset only synchronizes.
    frame(32, 64'hDEADBEEF, 64'h12345678, 6'd32, 1'b0);
    frame(32, 64'h8000_0001, 64'h7FFF_FFFE, 6'd32, 1'b0);
    frame(64, {40'hA5A5A5A5A5, 24'h800000}, {40'h123456789A, 24'h000123}, 6'd24, 1'b0);
    frame(20, 64'h0000_0000_000F_0F0F, 64'h0000_0000_000A_AAAA, 6'd24, 1'b0);
    frame(32, 64'h0000_0000_1357_9BDF, 64'h0000_0000_FDB9_7531, 6'd32, 1'b1);
    for (int k = 0; k < 4; k++)
      frame(32, {32'd0, $urandom}, {32'd0, $urandom}, dlist[k], 1'b0);
    frame(18, 64'h0002_0001, 64'h0001_FFFF, 6'd8, 1'b0);
    frame(130, {$urandom, $urandom}, {$urandom, $urandom}, 6'd32, 1'b0);

    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    do_reset("midreset");
    latch(6'd32, 1'b0, 1'b0, 1'b0);
    frame(32, 64'hCAFE_F00D, 64'h0BAD_BEEF, 6'd32, 1'b0);

    repeat (20) @(negedge clk);
    check("pending_frames", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
